// File: rtl/multicycle_ctrl_v2_if.sv
// multicycle_ctrl_v2_if: controller <-> decoder/datapath/memory signal bundle
interface multicycle_ctrl_v2_if #(parameter int XLEN = 32);
   logic [13:0]     execution;
   logic [XLEN-1:0] ALU_data2, rd2, pc_addr_plus, ALUresult, rd_data;
   logic            ALUzero, mem_ready, resume;
   logic            load_inst, dec_en, ALUenable, mem_rd, mem_wr, regwrite, jump, branch, inc_pc;
   logic [XLEN-1:0] wd, data2, instret;
   logic [5:0]      ALUcommand;
   logic            halted, illegal, mem_err;
   modport master (
      input  execution, ALU_data2, rd2, ALUzero, pc_addr_plus, ALUresult, rd_data, mem_ready, resume,
      output load_inst, dec_en, ALUenable, mem_rd, mem_wr, regwrite, jump, branch, inc_pc,
             wd, data2, ALUcommand, halted, illegal, mem_err, instret
   );
   modport slave (
      output execution, ALU_data2, rd2, ALUzero, pc_addr_plus, ALUresult, rd_data, mem_ready, resume,
      input  load_inst, dec_en, ALUenable, mem_rd, mem_wr, regwrite, jump, branch, inc_pc,
             wd, data2, ALUcommand, halted, illegal, mem_err, instret
   );
endinterface

// File: rtl/multicycle_ctrl_v2.sv
// multicycle_ctrl_v2: multi-cycle instruction sequencer; define CTRL_PERF_CNT_EN for the instret counter
module multicycle_ctrl_v2 #(
   parameter int XLEN        = 32,
   parameter int WAIT_W      = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input logic                  clk,
   input logic                  rst,
   multicycle_ctrl_v2_if.master bus
);
   typedef enum logic [2:0] {FETCH, DECODE, CONTROL, EXEC, MEM_WAIT, WRITEBACK, CHANGE_PC, HALTED} state_t;
   state_t            state_q, state_d;
   logic [8:0]        stb_q, stb_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]   ld_q, ld_d;
   logic [5:0]        cmd_q, cmd_d;
   logic [2:0]        sel_q, sel_d;
   logic              src_q, src_d, halted_q, halted_d, illegal_q, illegal_d, mem_err_q, mem_err_d;
   logic [13:0]       op;
   logic              legal, mem_op, wr_op, taken;
   assign op     = bus.execution;
   assign legal  = $onehot(op);
   assign mem_op = op[0] | op[2];
   assign wr_op  = |{op[0], op[1], op[4], op[5], op[6], op[7], op[8], op[9], op[11], op[13]};
   assign taken  = (op[3] & bus.ALUzero) | (op[12] & ~bus.ALUzero);
   // next state, memory wait/timeout tracking, and registered outputs decoded from the state being entered
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ld_d      = ld_q;
      illegal_d = illegal_q;
      mem_err_d = mem_err_q;
      case (state_q)
         FETCH:     state_d = DECODE;
         DECODE:    state_d = CONTROL;
         CONTROL: begin
            state_d   = !legal ? CHANGE_PC : op[10] ? HALTED : EXEC;
            illegal_d = illegal_q | ~legal;
         end
         EXEC:      state_d = mem_op ? MEM_WAIT : WRITEBACK;
         MEM_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.mem_ready) begin
               state_d = WRITEBACK;
               cnt_d   = '0;
               ld_d    = op[0] ? bus.rd_data : ld_q;
            end else if (cnt_d == WAIT_W'(MEM_TIMEOUT)) begin
               state_d   = CHANGE_PC;
               cnt_d     = '0;
               mem_err_d = 1'b1;
            end
         end
         WRITEBACK: state_d = CHANGE_PC;
         CHANGE_PC: state_d = FETCH;
         HALTED:    state_d = bus.resume ? CHANGE_PC : HALTED;
         default:   state_d = FETCH;
      endcase
      stb_d = {state_d inside {FETCH, DECODE},
               state_d == DECODE,
               (state_d == EXEC && !op[9]) || state_d == MEM_WAIT,
               state_d == MEM_WAIT && op[0],
               state_d == MEM_WAIT && op[2],
               state_d == CHANGE_PC && state_q == WRITEBACK && wr_op,
               state_d == WRITEBACK ? op[9] : (state_d == CHANGE_PC && stb_q[2]),
               state_d == WRITEBACK ? taken : (state_d == CHANGE_PC && stb_q[1]),
               state_d == CHANGE_PC};
      halted_d = state_d == HALTED;
      {src_d, cmd_d} = (state_d == CONTROL && legal && !op[9] && !op[10])
         ? {op[0] | op[1] | op[2] | op[13],
            op[11], op[8], op[7], op[1] | op[6], op[0] | op[2] | op[4] | op[13], op[3] | op[5] | op[12]}
         : {src_q, cmd_q};
      sel_d = state_d == WRITEBACK ? (op[9] ? 3'b001 : op[0] ? 3'b100 : 3'b010) : sel_q;
   end
   // state and output registers; reset aborts any memory access at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= FETCH;
         stb_q     <= '0;
         cnt_q     <= '0;
         ld_q      <= '0;
         cmd_q     <= '0;
         src_q     <= 1'b0;
         sel_q     <= 3'b010;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         stb_q     <= stb_d;
         cnt_q     <= cnt_d;
         ld_q      <= ld_d;
         cmd_q     <= cmd_d;
         src_q     <= src_d;
         sel_q     <= sel_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         mem_err_q <= mem_err_d;
      end
   end
   assign {bus.load_inst, bus.dec_en, bus.ALUenable, bus.mem_rd, bus.mem_wr,
           bus.regwrite, bus.jump, bus.branch, bus.inc_pc} = stb_q;
   assign bus.ALUcommand = cmd_q;
   assign bus.halted     = halted_q;
   assign bus.illegal    = illegal_q;
   assign bus.mem_err    = mem_err_q;
   assign bus.data2      = src_q ? bus.ALU_data2 : bus.rd2;
   assign bus.wd         = ({XLEN{sel_q[0]}} & bus.pc_addr_plus) | ({XLEN{sel_q[1]}} & bus.ALUresult)
                         | ({XLEN{sel_q[2]}} & ld_q);
`ifdef CTRL_PERF_CNT_EN
   logic [XLEN-1:0] instret_q, instret_d;
   // every instruction reaching writeback retires on the way into CHANGE_PC
   always_comb instret_d = instret_q + {{(XLEN-1){1'b0}}, state_q == WRITEBACK};
   // retired-instruction counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) instret_q <= '0;
      else instret_q <= instret_d;
   end
   assign bus.instret = instret_q;
`else
   assign bus.instret = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// tb_multicycle_ctrl_v2: randomized instruction stream checked cycle-by-cycle against a per-instruction timeline model
module tb_multicycle_ctrl_v2;
   localparam int XLEN = 32;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   multicycle_ctrl_v2_if #(.XLEN(XLEN)) bus ();
   multicycle_ctrl_v2 #(.XLEN(XLEN), .WAIT_W(4), .MEM_TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
   // s = {load_inst,dec_en,ALUenable,mem_rd,mem_wr,regwrite,jump,branch,inc_pc,halted,illegal,mem_err}
   typedef struct packed {
      logic [11:0] s;
      logic        chk_wd;
      logic [31:0] wd;
      logic [5:0]  cmd;
      logic [31:0] d2;
      logic [31:0] instret;
   } exp_t;
   typedef struct packed {
      logic        rdy;
      logic        res;
      logic [31:0] rd;
      exp_t        e;
   } cyc_t;
   exp_t        eq[$];
   cyc_t        plan[$];
   exp_t        ce;
   int          checks = 0;
   int          errors = 0;
   int          exp5;
   logic [13:0] m_exec;
   logic [31:0] m_imm, m_rd2, m_res, m_pc, m_rdr, m_ir;
   logic        m_zero, m_src, m_ill, m_err, m_first;
   logic [5:0]  m_cmd;
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask
   function automatic logic [11:0] dut_s();
      return {bus.load_inst, bus.dec_en, bus.ALUenable, bus.mem_rd, bus.mem_wr, bus.regwrite,
              bus.jump, bus.branch, bus.inc_pc, bus.halted, bus.illegal, bus.mem_err};
   endfunction
   function automatic logic [5:0] cmd_of(input int k);
      case (k)
         0, 2, 4, 13: return 6'b000010;
         1, 6:        return 6'b000100;
         3, 5, 12:    return 6'b000001;
         7:           return 6'b001000;
         8:           return 6'b010000;
         11:          return 6'b100000;
         default:     return 6'b000000;
      endcase
   endfunction
   function automatic logic wr_of(input int k);
      return k inside {0, 1, 4, 5, 6, 7, 8, 9, 11, 13};
   endfunction
   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction
   function automatic int count_bit(input int b);
      int n = 0;
      foreach (plan[i]) n += int'(plan[i].e.s[b]);
      return n;
   endfunction
   task automatic model_reset();
      m_cmd = '0; m_src = 0; m_ill = 0; m_err = 0; m_ir = '0; m_first = 1;
   endtask
   task automatic rnd();
      m_imm = $urandom; m_rd2 = $urandom; m_res = $urandom; m_pc = $urandom;
      m_rdr = $urandom; m_zero = rb();
   endtask
   task automatic add(input logic [8:0] st, input logic h, input logic cw, input logic [31:0] w,
                      input logic rdy, input logic res, input logic [31:0] rd);
      cyc_t c;
      c.rdy = rdy; c.res = res; c.rd = rd;
      c.e.s = {st, h, m_ill, m_err};
      c.e.chk_wd = cw; c.e.wd = w; c.e.cmd = m_cmd;
      c.e.d2 = m_src ? m_imm : m_rd2;
      c.e.instret = m_ir;
      plan.push_back(c);
   endtask
   // k: 0..13 one-hot op index, 14 all-zero, 15 multi-hot; n: MEM_WAIT cycle with ready (>15 never); hn: halted cycles
   task automatic build(input int k, input int n, input int hn);
      logic        tk, jl;
      logic [31:0] w, r;
      int          a, b;
      if (k < 14) m_exec = 14'd1 << k;
      else if (k == 14) m_exec = '0;
      else begin
         a = $urandom_range(0, 13);
         b = (a + $urandom_range(1, 13)) % 14;
         m_exec = (14'd1 << a) | (14'd1 << b);
      end
      add(m_first ? 9'h000 : 9'h100, 0, 0, 0, rb(), rb(), $urandom);
      m_first = 0;
      add(9'h180, 0, 0, 0, rb(), rb(), $urandom);
      if (k < 14 && k != 9 && k != 10) begin
         m_cmd = cmd_of(k);
         m_src = k inside {0, 1, 2, 13};
      end
      add(9'h000, 0, 0, 0, rb(), rb(), $urandom);
      if (k >= 14) begin
         m_ill = 1;
         add(9'h001, 0, 0, 0, rb(), rb(), $urandom);
      end else if (k == 10) begin
         for (int i = 1; i <= hn; i++) add(9'h000, 1, 0, 0, rb(), i == hn, $urandom);
         add(9'h001, 0, 0, 0, rb(), rb(), $urandom);
      end else begin
         add(k == 9 ? 9'h000 : 9'h040, 0, 0, 0, rb(), rb(), $urandom);
         if (k == 0 || k == 2)
            for (int i = 1; i <= n && i <= 15; i++) begin
               r = (i == n) ? m_rdr : $urandom;
               add(k == 0 ? 9'h060 : 9'h050, 0, 0, 0, i == n, rb(), r);
            end
         if ((k == 0 || k == 2) && n > 15) begin
            m_err = 1;
            add(9'h001, 0, 0, 0, rb(), rb(), $urandom);
         end else begin
            tk = (k == 3 && m_zero) || (k == 12 && !m_zero);
            jl = k == 9;
            w  = jl ? m_pc : k == 0 ? m_rdr : m_res;
            add({6'b0, jl, tk, 1'b0}, 0, 1, w, rb(), rb(), $urandom);
`ifdef CTRL_PERF_CNT_EN
            m_ir = m_ir + 1;
`endif
            add({5'b0, wr_of(k), jl, tk, 1'b1}, 0, 1, w, rb(), rb(), $urandom);
         end
      end
   endtask
   task automatic play(input int cnt);
      cyc_t c;
      bus.execution = m_exec; bus.ALU_data2 = m_imm; bus.rd2 = m_rd2;
      bus.ALUresult = m_res; bus.pc_addr_plus = m_pc; bus.ALUzero = m_zero;
      for (int i = 0; plan.size() != 0 && (cnt < 0 || i < cnt); i++) begin
         c = plan.pop_front();
         bus.mem_ready = c.rdy; bus.resume = c.res; bus.rd_data = c.rd;
         eq.push_back(c.e);
         @(posedge clk);
         #1;
      end
   endtask
   // compare every planned cycle against the DUT mid-cycle
   always @(negedge clk) begin
      if (eq.size() != 0) begin
         ce = eq.pop_front();
         chk("strobes", 32'(dut_s()), 32'(ce.s));
         chk("ALUcommand", 32'(bus.ALUcommand), 32'(ce.cmd));
         chk("data2", bus.data2, ce.d2);
         chk("instret", bus.instret, ce.instret);
         if (ce.chk_wd) chk("wd", bus.wd, ce.wd);
      end
   end
   initial begin
`ifdef CTRL_PERF_CNT_EN
      exp5 = 5;
`else
      exp5 = 0;
`endif
      bus.execution = '0; bus.ALU_data2 = '0; bus.rd2 = '0; bus.ALUzero = 0; bus.pc_addr_plus = '0;
      bus.ALUresult = 32'h1234_5678; bus.rd_data = '0; bus.mem_ready = 0; bus.resume = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_strobes", 32'(dut_s()), 0);
      chk("rst_cmd", 32'(bus.ALUcommand), 0);
      chk("rst_wd", bus.wd, 32'h1234_5678);
      chk("rst_instret", bus.instret, 0);
      rst = 1;
      rnd(); m_res = 32'h7; build(4, 0, 0);
      chk("add_len", plan.size(), 6);
      chk("add_rw_c6", 32'(plan[5].e.s[6]), 1);
      chk("add_wd", plan[5].e.wd, 32'h7);
      chk("add_cmd", 32'(plan[5].e.cmd), 32'h2);
      play(-1);
      rnd(); m_rdr = 32'hDEAD_BEEF; build(0, 3, 0);
      chk("lw_len", plan.size(), 9);
      chk("lw_mem_rd", count_bit(8), 3);
      chk("lw_wd", plan[8].e.wd, 32'hDEAD_BEEF);
      play(-1);
      rnd(); m_zero = 0; build(12, 0, 0);
      chk("bne_br_wb", 32'(plan[4].e.s[4]), 1);
      chk("bne_br_cpc", 32'(plan[5].e.s[4]), 1);
      play(-1);
      rnd(); m_zero = 0; build(3, 0, 0);
      chk("beq_br", 32'(plan[4].e.s[4]), 0);
      play(-1);
      rnd(); build(0, 15, 0);
      chk("lw_ready_at_timeout_len", plan.size(), 21);
      play(-1);
      rnd(); build(2, 16, 0);
      chk("sw_to_len", plan.size(), 20);
      chk("sw_mem_wr", count_bit(7), 15);
      chk("sw_rw", count_bit(6), 0);
      play(-1);
      chk("sw_mem_err", 32'(bus.mem_err), 1);
      rnd(); build(10, 0, 11);
      chk("halt_len", plan.size(), 15);
      chk("halt_cycles", count_bit(2), 11);
      play(-1);
      rnd(); build(14, 0, 0);
      play(-1);
      chk("illegal_zero", 32'(bus.illegal), 1);
      for (int i = 0; i < 60; i++) begin
         rnd();
         build($urandom_range(0, 15), ($urandom_range(0, 5) == 0) ? 16 : $urandom_range(1, 4), $urandom_range(1, 4));
         play(-1);
      end
      rnd(); build(0, 16, 0);
      play(5);
      plan.delete();
      chk("mw_mem_rd", 32'(bus.mem_rd), 1);
      #2 rst = 0;
      #1 chk("rst_async", 32'(dut_s()), 0);
      @(posedge clk);
      #1 chk("rst_hold", 32'(dut_s()), 0);
      chk("rst_cmd2", 32'(bus.ALUcommand), 0);
      rst = 1;
      model_reset();
      repeat (5) begin
         rnd(); build(4, 0, 0); play(-1);
      end
      chk("instret5", bus.instret, 32'(exp5));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
